// File: rtl/issue_scoreboard.sv
// Dual-issue register scoreboard with drain FSM and single-cycle flush.
// Optional ISSUE_SB_BYPASS_EN: sources become ready in the cycle of their writeback.
module issue_scoreboard #(
   parameter int REG_NUM    = 32,
   parameter int CNT_W      = 2,
   parameter int INFLIGHT_W = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_0,
   input  logic [4:0]            rs1_0,
   input  logic [4:0]            rs2_0,
   input  logic [4:0]            rd_0,
   input  logic                  re1_0,
   input  logic                  re2_0,
   input  logic                  we_0,
   input  logic                  valid_1,
   input  logic [4:0]            rs1_1,
   input  logic [4:0]            rs2_1,
   input  logic [4:0]            rd_1,
   input  logic                  re1_1,
   input  logic                  re2_1,
   input  logic                  we_1,
   output logic                  issue_0,
   output logic                  issue_1,
   input  logic                  wb_we_1,
   input  logic                  wb_we_2,
   input  logic [4:0]            wb_addr_1,
   input  logic [4:0]            wb_addr_2,
   input  logic                  flush,
   input  logic                  drain_req,
   output logic                  drain_busy,
   output logic                  drain_done,
   output logic [INFLIGHT_W-1:0] inflight_cnt,
   output logic                  wb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {RUN, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q [REG_NUM];
   logic [CNT_W-1:0]      cnt_d [REG_NUM];
   logic [1:0]            ret   [REG_NUM];
   logic [INFLIGHT_W-1:0] infl_q, infl_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  gate, w0, raw, waw;

   function automatic logic src_ok(input logic en, input logic [4:0] a);
      logic [CNT_W:0] c;
      c = {1'b0, cnt_q[a]};
      src_ok = !en || (a == 5'd0) || (c == '0);
`ifdef ISSUE_SB_BYPASS_EN
      src_ok = src_ok || (c <= (CNT_W+1)'(ret[a]));
`endif
   endfunction

   function automatic logic dst_ok(input logic en, input logic [4:0] a);
      dst_ok = !en || (a == 5'd0) || (cnt_q[a] != CNT_MAX);
   endfunction

   always_comb begin
      for (int r = 0; r < REG_NUM; r++) begin
         ret[r] = {1'b0, wb_we_1 && (wb_addr_1 == 5'(r))}
                + {1'b0, wb_we_2 && (wb_addr_2 == 5'(r))};
      end
   end

   assign gate = rst && (state_q == RUN) && !drain_req && !flush;
   assign w0   = we_0 && (rd_0 != 5'd0);
   assign raw  = w0 && ((re1_1 && (rs1_1 == rd_0)) ||
                        (re2_1 && (rs2_1 == rd_0)));
   assign waw  = w0 && we_1 && (rd_1 == rd_0);

   assign issue_0 = gate && valid_0 &&
                    src_ok(re1_0, rs1_0) && src_ok(re2_0, rs2_0) &&
                    dst_ok(we_0, rd_0);
   assign issue_1 = issue_0 && valid_1 && !raw && !waw &&
                    src_ok(re1_1, rs1_1) && src_ok(re2_1, rs2_1) &&
                    dst_ok(we_1, rd_1);

   always_comb begin : upd
      logic [1:0]            a;
      logic [CNT_W+1:0]      sum;
      logic [CNT_W+1:0]      rr;
      logic [INFLIGHT_W-1:0] alloc_n;
      logic [INFLIGHT_W-1:0] ret_n;
      state_d = state_q;
      done_d  = 1'b0;
      err_d   = err_q;
      alloc_n = '0;
      ret_n   = '0;
      a       = '0;
      sum     = '0;
      rr      = '0;
      for (int r = 0; r < REG_NUM; r++) cnt_d[r] = cnt_q[r];
      // Net alloc/retire per register; retiring more than is pending clamps.
      for (int r = 1; r < REG_NUM; r++) begin
         a   = {1'b0, issue_0 && w0 && (rd_0 == 5'(r))}
             + {1'b0, issue_1 && we_1 && (rd_1 == 5'(r))};
         sum = {2'b00, cnt_q[r]} + {{CNT_W{1'b0}}, a};
         rr  = {{CNT_W{1'b0}}, ret[r]};
         alloc_n = alloc_n + INFLIGHT_W'(a);
         if (sum < rr) begin
            cnt_d[r] = '0;
            err_d    = 1'b1;
            ret_n    = ret_n + INFLIGHT_W'(sum);
         end else begin
            cnt_d[r] = CNT_W'(sum - rr);
            ret_n    = ret_n + INFLIGHT_W'(rr);
         end
      end
      infl_d = infl_q + alloc_n - ret_n;
      unique case (state_q)
         RUN:   if (drain_req) state_d = DRAIN;
         DRAIN: if (infl_q == '0 && !wb_we_1 && !wb_we_2) begin
            state_d = RUN;
            done_d  = 1'b1;
         end
         default: state_d = RUN;
      endcase
      if (flush) begin
         for (int r = 0; r < REG_NUM; r++) cnt_d[r] = '0;
         infl_d  = '0;
         state_d = RUN;
         done_d  = 1'b0;
         err_d   = err_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= '0;
         state_q <= RUN;
         infl_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         for (int r = 0; r < REG_NUM; r++) cnt_q[r] <= cnt_d[r];
         state_q <= state_d;
         infl_q  <= infl_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign inflight_cnt = infl_q;
   assign drain_busy   = (state_q == DRAIN);
   assign drain_done   = done_q;
   assign wb_err       = err_q;

endmodule
